cpu_fetch_stage: RTL and testbench
==================================

// Module: cpu_fetch_stage
// PURPOSE
//  Instruction fetch stage; master (driving) end of CPU_decode_if.master. Holds the PC and issues
//  word reads to the instruction memory port. Registers each returned word onto the decode interface
//  as instr / valid_instr / next_PC. Handles decode stalls with a 1-entry skid buffer.
//  Handles branch/jump/IRET/exception redirects by discarding in-flight and buffered words.
// PARAMETERS
//  VIRTUAL_ADDR_WIDTH  `VIRTUAL_ADDR_WIDTH   PC / address width (bits)
//  BOOT_PC             'h1000                PC loaded on reset; must be 4-byte aligned
// PORTS
//  clk             in   1    clock, all state on rising edge
//  rst_n           in   1    asynchronous active-low reset
//  imem_req_valid  out  1    fetch request valid
//  imem_req_addr   out  VA   word address of request, bits[1:0]=0
//  imem_req_ready  in   1    memory accepts request (transfer = valid & ready)
//  imem_resp_valid in   1    response word valid (1 cycle pulse per accepted request)
//  imem_resp_data  in   32   instruction word
//  stall           in   1    decode cannot accept; hold decode outputs
//  redirect_valid  in   1    change of flow this cycle
//  redirect_pc     in   VA   new PC; bits[1:0] ignored (forced 0)
//  dec.next_PC     out  VA   address of instruction after dec.instr (= its PC + 4)
//  dec.valid_instr out  1    dec.instr holds a valid instruction
//  dec.instr       out  32   instruction word (instr_t)
// BEHAVIOUR
//  Reset (async on rst_n low): pc=BOOT_PC, state=FETCH, drop=0, skid empty, imem_req_valid=0,
//   imem_req_addr=BOOT_PC, valid_instr=0, instr=0, next_PC=BOOT_PC. First request in the cycle
//   after rst_n rises. Reset mid-transaction abandons everything; a late response is ignored (state FETCH).
//  At most one outstanding request. States:
//   FETCH: imem_req_valid=1 iff skid empty; addr=pc. On valid&ready -> WAIT, pc <= pc+4.
//   WAIT : imem_req_valid=0. On imem_resp_valid -> FETCH.
//   addr/valid stable until accepted, except on redirect (below).
//  Response handling (WAIT, resp_valid, drop=0), word W with PC = pc-4:
//   - output free (valid_instr=0 or stall=0): instr<=W, valid_instr<=1, next_PC<=pc.
//   - output held (valid_instr=1 and stall=1): W + its next_PC go to skid.
//  Output advance when stall=0: skid full -> skid to output, skid empties; else a response
//   (if any) loads output; else valid_instr<=0. Response while skid drains loads the output
//   (only when skid empty) — by construction it cannot coincide since no request issues while skid full.
//  stall=1: dec.* held unchanged, no output advance.
//  Redirect (priority over stall and response; redirect_valid=1 in cycle N):
//   - cycle N+1: valid_instr=0, skid empty, pc=redirect_pc & ~3.
//   - in WAIT with no resp in N, or FETCH with request accepted in N: drop<=1; next response
//     discarded, clears drop; then FETCH from new pc.
//   - in WAIT with resp in N: resp discarded, -> FETCH.
//   - FETCH not accepted: request re-presented with new address from N+1 (allowed exception).
//  Redirect and stall in same cycle: redirect wins; output invalidated.
//  Arithmetic: pc+4 modulo 2^VA; 'hFFFF_FFFC wraps to 0, next_PC reported as 0.
//  Throughput: one instruction per 2 cycles min with 1-cycle memory (single outstanding).
// TESTING
//  1 Reset, mem ready=1, 1-cycle latency -> req addr 'h1000,'h1004,'h1008; dec.next_PC 'h1004,'h1008,...
//  2 stall=1 while valid_instr=1 and a response 'hAAAA arrives -> dec.* unchanged, req_valid=0;
//    stall=0 -> 'hAAAA shown next cycle with correct next_PC, fetching resumes.
//  3 Redirect to 'h2002 while in WAIT -> late response dropped, valid_instr=0, next req addr 'h2000.
//  4 redirect_valid and stall both 1 with skid full -> valid_instr=0 and skid empty next cycle.
//  5 BOOT_PC='hFFFF_FFFC -> first dec.next_PC=0, second request addr 0.
//  6 rst_n low while in WAIT with pending response -> outputs reset immediately; stray resp ignored.

Source files
------------

// File: rtl/cpu_fetch_stage.sv
// Instruction fetch stage: holds the PC, issues single-outstanding word reads to instruction memory
// and presents returned words to decode, with a 1-entry skid buffer for stalls and redirect flushing.
module cpu_fetch_stage #(
    parameter int unsigned                    VIRTUAL_ADDR_WIDTH = 32,
    parameter logic [VIRTUAL_ADDR_WIDTH-1:0]  BOOT_PC            = 32'h0000_1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_req_valid_o,
    output logic [VIRTUAL_ADDR_WIDTH-1:0] imem_req_addr_o,
    input  logic                          imem_req_ready_i,
    input  logic                          imem_resp_valid_i,
    input  logic [31:0]                   imem_resp_data_i,
    input  logic                          stall_i,
    input  logic                          redirect_valid_i,
    input  logic [VIRTUAL_ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [VIRTUAL_ADDR_WIDTH-1:0] dec_next_pc_o,
    output logic                          dec_valid_instr_o,
    output logic [31:0]                   dec_instr_o
);

    localparam int unsigned VA = VIRTUAL_ADDR_WIDTH;

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] WAIT  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [VA-1:0] pc_q, pc_d;
    logic          drop_q, drop_d;
    logic          req_valid_q, req_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [31:0]   skid_instr_q, skid_instr_d;
    logic [VA-1:0] skid_npc_q, skid_npc_d;
    logic          valid_q, valid_d;
    logic [31:0]   instr_q, instr_d;
    logic [VA-1:0] npc_q, npc_d;

    logic          req_fire_s;
    logic          resp_s;
    logic          take_s;
    logic [VA-1:0] pc_inc_s;
    logic [VA-1:0] redirect_pc_s;

    assign req_fire_s    = req_valid_q & imem_req_ready_i;
    assign resp_s        = (state_q == WAIT) & imem_resp_valid_i;
    assign take_s        = resp_s & ~drop_q;
    assign pc_inc_s      = pc_q + {{(VA-3){1'b0}}, 3'd4};
    assign redirect_pc_s = {redirect_pc_i[VA-1:2], 2'b00};

    // Next-state for fetch FSM, PC, drop flag, skid buffer and decode outputs
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        npc_d        = npc_q;
        if (redirect_valid_i) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = redirect_pc_s;
            case (state_q)
                FETCH: begin
                    if (req_fire_s) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
                WAIT: begin
                    // A response in the redirect cycle is simply discarded; otherwise the next one is
                    if (imem_resp_valid_i) begin
                        state_d = FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_fire_s) begin
                        state_d = WAIT;
                        pc_d    = pc_inc_s;
                    end else begin
                        state_d = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid_i) begin
                        state_d = FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
            // In WAIT pc_q already points past the returning word, so it is that word's next_PC
            if (valid_q && stall_i) begin
                if (take_s) begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = imem_resp_data_i;
                    skid_npc_d   = pc_q;
                end else begin
                    skid_valid_d = skid_valid_q;
                end
            end else if (skid_valid_q) begin
                valid_d      = 1'b1;
                instr_d      = skid_instr_q;
                npc_d        = skid_npc_q;
                skid_valid_d = 1'b0;
            end else if (take_s) begin
                valid_d = 1'b1;
                instr_d = imem_resp_data_i;
                npc_d   = pc_q;
            end else begin
                valid_d = 1'b0;
            end
        end
        req_valid_d = (state_d == FETCH) && !skid_valid_d;
    end

    // State registers with asynchronous reset to the boot PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= BOOT_PC;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0000_0000;
            skid_npc_q   <= BOOT_PC;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0000_0000;
            npc_q        <= BOOT_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            req_valid_q  <= req_valid_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            npc_q        <= npc_d;
        end
    end

    assign imem_req_valid_o  = req_valid_q;
    assign imem_req_addr_o   = pc_q;
    assign dec_valid_instr_o = valid_q;
    assign dec_instr_o       = instr_q;
    assign dec_next_pc_o     = npc_q;

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Directed bench for cpu_fetch_stage: linear steps with hand-computed expectations; a second
// instance booting at 'hFFFF_FFFC shares the stimulus to check PC wrap.
module tb_cpu_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_ready = 1'b1;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = 32'h0000_0000;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;

    logic        req_valid, req_valid2;
    logic [31:0] req_addr, req_addr2;
    logic [31:0] next_pc, next_pc2;
    logic        valid_instr, valid_instr2;
    logic [31:0] instr, instr2;

    int tests = 0;
    int fails = 0;
    logic        auto_resp = 1'b1;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0000_0000;

    cpu_fetch_stage #(.VIRTUAL_ADDR_WIDTH(32), .BOOT_PC(32'h0000_1000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid_o(req_valid), .imem_req_addr_o(req_addr), .imem_req_ready_i(req_ready),
        .imem_resp_valid_i(resp_valid), .imem_resp_data_i(resp_data),
        .stall_i(stall), .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .dec_next_pc_o(next_pc), .dec_valid_instr_o(valid_instr), .dec_instr_o(instr)
    );

    cpu_fetch_stage #(.VIRTUAL_ADDR_WIDTH(32), .BOOT_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid_o(req_valid2), .imem_req_addr_o(req_addr2), .imem_req_ready_i(req_ready),
        .imem_resp_valid_i(resp_valid), .imem_resp_data_i(resp_data),
        .stall_i(stall), .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .dec_next_pc_o(next_pc2), .dec_valid_instr_o(valid_instr2), .dec_instr_o(instr2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the memory model answers an accepted request one cycle later with C000_0000|addr
    task automatic tick();
        logic        xfer;
        logic [31:0] a;
        xfer = req_valid & req_ready;
        a    = req_addr;
        @(posedge clk);
        #1;
        if (auto_resp) begin
            resp_valid = xfer;
            resp_data  = ovr_en ? ovr_data : (32'hC000_0000 | a);
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'd0, req_valid}, 32'h0000_0000);
        chk("rst_req_addr", req_addr, 32'h0000_1000);
        chk("rst_valid", {31'd0, valid_instr}, 32'h0000_0000);
        chk("rst_instr", instr, 32'h0000_0000);
        chk("rst_next_pc", next_pc, 32'h0000_1000);
        chk("rst_wrap_addr", req_addr2, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        // 1: streaming with ready=1 and 1-cycle latency
        tick();
        chk("t1_req0_valid", {31'd0, req_valid}, 32'h0000_0001);
        chk("t1_req0_addr", req_addr, 32'h0000_1000);
        tick();
        chk("t1_wait_req_valid", {31'd0, req_valid}, 32'h0000_0000);
        tick();
        chk("t1_i0_valid", {31'd0, valid_instr}, 32'h0000_0001);
        chk("t1_i0_instr", instr, 32'hC000_1000);
        chk("t1_i0_npc", next_pc, 32'h0000_1004);
        chk("t1_req1_addr", req_addr, 32'h0000_1004);
        // 5: wrap instance
        chk("t5_wrap_npc", next_pc2, 32'h0000_0000);
        chk("t5_wrap_req_addr", req_addr2, 32'h0000_0000);
        chk("t5_wrap_valid", {31'd0, valid_instr2}, 32'h0000_0001);
        tick();
        tick();
        chk("t1_i1_instr", instr, 32'hC000_1004);
        chk("t1_i1_npc", next_pc, 32'h0000_1008);
        chk("t1_req2_addr", req_addr, 32'h0000_1008);

        // 2: stall with response landing in skid
        stall = 1'b1;
        ovr_en = 1'b1;
        ovr_data = 32'h0000_AAAA;
        tick();
        tick();
        chk("t2_hold_instr", instr, 32'hC000_1004);
        chk("t2_hold_npc", next_pc, 32'h0000_1008);
        chk("t2_hold_valid", {31'd0, valid_instr}, 32'h0000_0001);
        chk("t2_req_blocked", {31'd0, req_valid}, 32'h0000_0000);
        tick();
        chk("t2_hold2_instr", instr, 32'hC000_1004);
        chk("t2_req_blocked2", {31'd0, req_valid}, 32'h0000_0000);
        stall = 1'b0;
        ovr_en = 1'b0;
        tick();
        chk("t2_skid_instr", instr, 32'h0000_AAAA);
        chk("t2_skid_npc", next_pc, 32'h0000_100C);
        chk("t2_skid_valid", {31'd0, valid_instr}, 32'h0000_0001);
        chk("t2_resume_valid", {31'd0, req_valid}, 32'h0000_0001);
        chk("t2_resume_addr", req_addr, 32'h0000_100C);

        // 3: redirect while waiting; the late response must be dropped
        auto_resp = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        chk("t3_redir_valid", {31'd0, valid_instr}, 32'h0000_0000);
        chk("t3_redir_req_valid", {31'd0, req_valid}, 32'h0000_0000);
        resp_valid = 1'b1;
        resp_data = 32'hDEAD_BEEF;
        tick();
        resp_valid = 1'b0;
        chk("t3_dropped_valid", {31'd0, valid_instr}, 32'h0000_0000);
        chk("t3_new_req_valid", {31'd0, req_valid}, 32'h0000_0001);
        chk("t3_new_req_addr", req_addr, 32'h0000_2000);
        auto_resp = 1'b1;
        tick();
        tick();
        chk("t3_new_instr", instr, 32'hC000_2000);
        chk("t3_new_npc", next_pc, 32'h0000_2004);

        // 4: redirect and stall together with skid full
        stall = 1'b1;
        tick();
        tick();
        chk("t4_skid_full_req", {31'd0, req_valid}, 32'h0000_0000);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        chk("t4_valid_cleared", {31'd0, valid_instr}, 32'h0000_0000);
        chk("t4_req_valid", {31'd0, req_valid}, 32'h0000_0001);
        chk("t4_req_addr", req_addr, 32'h0000_3000);
        tick();
        chk("t4_skid_empty", {31'd0, valid_instr}, 32'h0000_0000);
        tick();
        chk("t4_new_instr", instr, 32'hC000_3000);
        chk("t4_new_npc", next_pc, 32'h0000_3004);

        // 6: reset while a response is pending
        auto_resp = 1'b0;
        tick();
        chk("t6_in_wait", {31'd0, req_valid}, 32'h0000_0000);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, valid_instr}, 32'h0000_0000);
        chk("t6_rst_instr", instr, 32'h0000_0000);
        chk("t6_rst_npc", next_pc, 32'h0000_1000);
        chk("t6_rst_addr", req_addr, 32'h0000_1000);
        resp_valid = 1'b1;
        resp_data = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_stray_ignored", {31'd0, valid_instr}, 32'h0000_0000);
        chk("t6_req_valid", {31'd0, req_valid}, 32'h0000_0001);
        chk("t6_req_addr", req_addr, 32'h0000_1000);
        resp_valid = 1'b0;
        auto_resp = 1'b1;
        tick();
        tick();
        chk("t6_first_instr", instr, 32'hC000_1000);
        chk("t6_first_npc", next_pc, 32'h0000_1004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
